// File: rtl/seq_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_mux_if
// Purpose  : Channel bus, select/start request and output handshake for
//            seq_mux. The o_par signal is present when SEQ_MUX_PARITY_EN
//            is defined.
// Revision : 1.0  initial release
// ============================================================================
interface seq_mux_if #(
  parameter int W = 8,
  parameter int N = 8
);
  localparam int SW = $clog2(N);

  logic [N*W-1:0] i;
  logic [SW-1:0]  s;
  logic           mode;
  logic           start;
  logic           o_rdy;
  logic [W-1:0]   o;
  logic [SW-1:0]  o_ch;
  logic           o_vld;
  logic           o_err;
  logic           busy;
`ifdef SEQ_MUX_PARITY_EN
  logic           o_par;

  modport master (
    output i, s, mode, start, o_rdy,
    input  o, o_ch, o_vld, o_err, busy, o_par
  );
  modport slave (
    input  i, s, mode, start, o_rdy,
    output o, o_ch, o_vld, o_err, busy, o_par
  );
`else
  modport master (
    output i, s, mode, start, o_rdy,
    input  o, o_ch, o_vld, o_err, busy
  );
  modport slave (
    input  i, s, mode, start, o_rdy,
    output o, o_ch, o_vld, o_err, busy
  );
`endif
endinterface
`default_nettype wire

// File: rtl/seq_mux.sv
`default_nettype none
// ============================================================================
// Module   : seq_mux
// Purpose  : Sequenced channel multiplexer: one manual read or a full scan
//            of N channels presented through a valid/ready output.
//            Optional feature macro: SEQ_MUX_PARITY_EN (adds o_par).
// Revision : 1.0  initial release
// ============================================================================
module seq_mux #(
  parameter int W = 8,
  parameter int N = 8
) (
  input  wire         clk,
  input  wire         rst_n,
  seq_mux_if.slave    mux_if
);
  localparam int              SW      = $clog2(N);
  localparam logic [SW-1:0]   LAST_CH = SW'(N - 1);
  localparam logic [SW:0]     N_EXT   = (SW + 1)'(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAN  = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t          state_q;
  logic [W-1:0]    o_q;
  logic [SW-1:0]   ch_q;
  logic            vld_q;
  logic            err_q;
  logic            busy_q;
  logic            par_q;

  logic [SW-1:0]   sel_idx_d;
  logic [W-1:0]    sel_data_d;
  logic            last_d;

  assign last_d = (ch_q == LAST_CH);

  // One shared mux serves every load: the first beat from IDLE and each scan advance.
  always_comb begin
    sel_idx_d = ch_q + SW'(1);
    if (state_q == IDLE) begin
      sel_idx_d = mux_if.mode ? '0 : mux_if.s;
    end
  end

  // Indices at or beyond N (non power-of-two N) select zero.
  always_comb begin
    sel_data_d = '0;
    for (int k = 0; k < N; k++) begin
      if (sel_idx_d == SW'(k)) begin
        sel_data_d = mux_if.i[k*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      o_q     <= '0;
      ch_q    <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mux_if.start) begin
            o_q    <= sel_data_d;
            par_q  <= ^sel_data_d;
            vld_q  <= 1'b1;
            busy_q <= 1'b1;
            if (mux_if.mode) begin
              state_q <= SCAN;
              ch_q    <= '0;
              err_q   <= 1'b0;
            end else begin
              state_q <= MAN;
              ch_q    <= mux_if.s;
              err_q   <= ({1'b0, mux_if.s} >= N_EXT);
            end
          end
        end
        MAN: begin
          if (mux_if.o_rdy) begin
            state_q <= IDLE;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        SCAN: begin
          if (mux_if.o_rdy) begin
            if (last_d) begin
              state_q <= IDLE;
              vld_q   <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              ch_q  <= sel_idx_d;
              o_q   <= sel_data_d;
              par_q <= ^sel_data_d;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          vld_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mux_if.o     = o_q;
  assign mux_if.o_ch  = ch_q;
  assign mux_if.o_vld = vld_q;
  assign mux_if.o_err = err_q;
  assign mux_if.busy  = busy_q;
`ifdef SEQ_MUX_PARITY_EN
  assign mux_if.o_par = par_q;
`else
  logic unused_par;
  assign unused_par = par_q;
`endif

endmodule
`default_nettype wire
